// File: rtl/dff_polarity_bank.sv
// Three independent holding-register lanes with mixed-polarity load enables and a delta-lane clear.
// One-cycle latency; no backpressure: each lane loads, clears or holds on every rising edge.
module dff_polarity_bank #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [WIDTH-1:0] d_alpha,
    input  logic             en_alpha,
    output logic [WIDTH-1:0] q_alpha,

    input  logic [WIDTH-1:0] d_beta,
    input  logic             en_beta_n,
    output logic [WIDTH-1:0] q_beta,

    input  logic [WIDTH-1:0] d_delta,
    input  logic             en_delta_n,
    input  logic             clr_delta_n,
    output logic [WIDTH-1:0] q_delta
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_alpha <= RESET_VALUE;
        end else if (en_alpha) begin
            q_alpha <= d_alpha;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_beta <= RESET_VALUE;
        end else if (!en_beta_n) begin
            q_beta <= d_beta;
        end
    end

    // Local clear wins over the load enable so a clear can never be masked by a pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_delta <= RESET_VALUE;
        end else if (!clr_delta_n) begin
            q_delta <= RESET_VALUE;
        end else if (!en_delta_n) begin
            q_delta <= d_delta;
        end
    end

endmodule

// File: tb/tb_dff_polarity_bank.sv
// Directed bench for dff_polarity_bank: a narrow (WIDTH=1) and a wide (WIDTH=8, reset 8'hA5) instance
// share clk/rst; expected lane values are queued at drive time and popped after each edge.
module tb_dff_polarity_bank;

    localparam logic [7:0] RV8 = 8'hA5;

    logic clk = 1'b0;
    logic rst;

    logic d_alpha, en_alpha, d_beta, en_beta_n, d_delta, en_delta_n, clr_delta_n;
    logic q_alpha, q_beta, q_delta;

    logic [7:0] w_d_alpha, w_d_beta, w_d_delta;
    logic       w_en_alpha, w_en_beta_n, w_en_delta_n, w_clr_delta_n;
    logic [7:0] w_q_alpha, w_q_beta, w_q_delta;

    typedef struct {
        logic       a;
        logic       b;
        logic       d;
        logic [7:0] wa;
        logic [7:0] wb;
        logic [7:0] wd;
    } exp_t;

    exp_t       sb_q[$];
    logic       m_a, m_b, m_d;
    logic [7:0] m_wa, m_wb, m_wd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_polarity_bank u_narrow (
        .clk         (clk),
        .rst         (rst),
        .d_alpha     (d_alpha),
        .en_alpha    (en_alpha),
        .q_alpha     (q_alpha),
        .d_beta      (d_beta),
        .en_beta_n   (en_beta_n),
        .q_beta      (q_beta),
        .d_delta     (d_delta),
        .en_delta_n  (en_delta_n),
        .clr_delta_n (clr_delta_n),
        .q_delta     (q_delta)
    );

    dff_polarity_bank #(.WIDTH(8), .RESET_VALUE(RV8)) u_wide (
        .clk         (clk),
        .rst         (rst),
        .d_alpha     (w_d_alpha),
        .en_alpha    (w_en_alpha),
        .q_alpha     (w_q_alpha),
        .d_beta      (w_d_beta),
        .en_beta_n   (w_en_beta_n),
        .q_beta      (w_q_beta),
        .d_delta     (w_d_delta),
        .en_delta_n  (w_en_delta_n),
        .clr_delta_n (w_clr_delta_n),
        .q_delta     (w_q_delta)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour evaluated from the inputs present just before the edge.
    task automatic step(input string tag);
        exp_t e;
        if (rst) begin
            m_a = 1'b0; m_b = 1'b0; m_d = 1'b0;
            m_wa = RV8; m_wb = RV8; m_wd = RV8;
        end else begin
            if (en_alpha === 1'b1)    m_a = d_alpha;
            if (en_beta_n === 1'b0)   m_b = d_beta;
            if (clr_delta_n === 1'b0) m_d = 1'b0;
            else if (en_delta_n === 1'b0) m_d = d_delta;
            if (w_en_alpha === 1'b1)    m_wa = w_d_alpha;
            if (w_en_beta_n === 1'b0)   m_wb = w_d_beta;
            if (w_clr_delta_n === 1'b0) m_wd = RV8;
            else if (w_en_delta_n === 1'b0) m_wd = w_d_delta;
        end
        e.a = m_a; e.b = m_b; e.d = m_d;
        e.wa = m_wa; e.wb = m_wb; e.wd = m_wd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() != 0) else begin
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk1({tag, "_q_alpha"}, q_alpha, e.a);
            chk1({tag, "_q_beta"},  q_beta,  e.b);
            chk1({tag, "_q_delta"}, q_delta, e.d);
            chk8({tag, "_w_q_alpha"}, w_q_alpha, e.wa);
            chk8({tag, "_w_q_beta"},  w_q_beta,  e.wb);
            chk8({tag, "_w_q_delta"}, w_q_delta, e.wd);
        end
    endtask

    task automatic narrow_idle();
        en_alpha = 1'b0; en_beta_n = 1'b1; en_delta_n = 1'b1; clr_delta_n = 1'b1;
    endtask

    task automatic wide_idle();
        w_en_alpha = 1'b0; w_en_beta_n = 1'b1; w_en_delta_n = 1'b1; w_clr_delta_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        d_alpha = 1'b0; d_beta = 1'b0; d_delta = 1'b0;
        w_d_alpha = 8'h00; w_d_beta = 8'h00; w_d_delta = 8'h00;
        narrow_idle();
        wide_idle();
        #2;

        // Reset with arbitrary data and control activity.
        for (int i = 0; i < 5; i++) begin
            {d_alpha, d_beta, d_delta} = 3'($urandom);
            {en_alpha, en_beta_n, en_delta_n, clr_delta_n} = 4'($urandom);
            w_d_alpha = 8'($urandom); w_d_beta = 8'($urandom); w_d_delta = 8'($urandom);
            {w_en_alpha, w_en_beta_n, w_en_delta_n, w_clr_delta_n} = 4'($urandom);
            step("reset");
        end
        rst = 1'b0;
        narrow_idle();
        wide_idle();
        d_alpha = 1'b1; d_beta = 1'b1; d_delta = 1'b1;
        step("post_reset_idle0");
        step("post_reset_idle1");

        // Enable polarity: load ones, then hold with enables inactive.
        en_alpha = 1'b1; en_beta_n = 1'b0; en_delta_n = 1'b0;
        step("enable_load");
        d_alpha = 1'b0; d_beta = 1'b0; d_delta = 1'b0;
        narrow_idle();
        for (int i = 0; i < 3; i++) step("enable_hold");

        // One shared enable: alpha and the active-low lanes take turns.
        for (int i = 0; i < 8; i++) begin
            logic e;
            e = (i < 4) ? 1'b1 : 1'b0;
            en_alpha = e; en_beta_n = e; en_delta_n = e;
            d_alpha = i[0]; d_beta = i[0]; d_delta = i[0];
            step(e ? "shared_en_hi" : "shared_en_lo");
        end

        // Delta clear beats its own enable; other lanes untouched.
        en_alpha = 1'b1; en_beta_n = 1'b0; en_delta_n = 1'b0;
        d_alpha = 1'b1; d_beta = 1'b1; d_delta = 1'b1;
        step("clr_preload");
        en_alpha = 1'b0; en_beta_n = 1'b1;
        d_alpha = 1'b0; d_beta = 1'b0;
        clr_delta_n = 1'b0;
        step("clr_active");
        clr_delta_n = 1'b1;
        step("clr_release");

        // Reset in the middle of active loading, then loading resumes.
        en_alpha = 1'b1; en_beta_n = 1'b0; en_delta_n = 1'b0;
        d_alpha = 1'b1; d_beta = 1'b1; d_delta = 1'b1;
        w_en_alpha = 1'b1; w_en_beta_n = 1'b0; w_en_delta_n = 1'b0;
        w_d_alpha = 8'h3C; w_d_beta = 8'hC3; w_d_delta = 8'h5A;
        step("midop_load");
        rst = 1'b1;
        step("midop_reset");
        rst = 1'b0;
        step("midop_resume");

        // Wide lanes: hold, local clear to 8'hA5, and a sub-cycle enable pulse.
        narrow_idle();
        wide_idle();
        w_d_alpha = 8'hFF; w_d_beta = 8'h00; w_d_delta = 8'h11;
        step("wide_hold");
        w_clr_delta_n = 1'b0; w_en_delta_n = 1'b0;
        step("wide_clr");
        wide_idle();
        w_d_alpha = 8'h01;
        #1 w_en_alpha = 1'b1;
        #3 w_en_alpha = 1'b0;
        step("wide_glitch");
        #1 en_alpha = 1'b1; d_alpha = 1'b0;
        #3 en_alpha = 1'b0; d_alpha = 1'b1;
        step("narrow_glitch");
        rst = 1'b1;
        step("wide_reset");
        rst = 1'b0;
        step("wide_reset_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
